// File: rtl/vga_box_tracker.sv
// Loopback receiver: recovers raster position from TinyVGA PMOD sync
// and publishes the bounding box of lit pixels once per frame.
//
// Ports:
//   clk, rst_n       pixel clock, async active-low reset
//   vga_in[7:0]      {hsync, B0, G0, R0, vsync, B1, G1, R1}
//   box_x0/x1/y0/y1  min/max lit x/y of last published frame
//   box_found        last published frame had a lit pixel
//   frame_valid      one-cycle pulse on publish
//   locked           sync timing acquired
//   frame_cnt        published-frame counter (wraps)
module vga_box_tracker #(
  parameter int H_START         = 48,
  parameter int H_ACTIVE        = 640,
  parameter int V_START         = 33,
  parameter int V_ACTIVE        = 480,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_in,
  output logic [9:0] box_x0,
  output logic [9:0] box_x1,
  output logic [9:0] box_y0,
  output logic [9:0] box_y1,
  output logic       box_found,
  output logic       frame_valid,
  output logic       locked,
  output logic [7:0] frame_cnt
);

  localparam logic       IDLE = SYNC_ACTIVE_LOW;
  localparam logic [7:0] S1_RST = {IDLE, 3'b000, IDLE, 3'b000};
  localparam logic [9:0] HMAX = 10'h3FF;
  localparam logic [9:0] HST  = 10'(H_START);
  localparam logic [9:0] HACT = 10'(H_ACTIVE);
  localparam logic [9:0] VST  = 10'(V_START);
  localparam logic [9:0] VACT = 10'(V_ACTIVE);

  typedef enum logic {
    UNLOCKED,
    TRACK
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] s1_q;
  logic [1:0] s2_q;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [9:0] minx_q, minx_d, maxx_q, maxx_d;
  logic [9:0] miny_q, miny_d, maxy_q, maxy_d;
  logic       seen_q, seen_d;
  logic [9:0] bx0_q, bx0_d, bx1_q, bx1_d;
  logic [9:0] by0_q, by0_d, by1_q, by1_d;
  logic       fnd_q, fnd_d;
  logic       fv_q, fv_d;
  logic [7:0] cnt_q, cnt_d;

  logic       hs1, hs2, vs1, vs2;
  logic       hs_end, vs_end, vs_beg;
  logic       lit, hit;
  logic [9:0] x, y;

  // Sync "active" flags; s2 only keeps the sync bits for edge detection.
  always_comb begin
    hs1    = s1_q[7] ^ SYNC_ACTIVE_LOW;
    vs1    = s1_q[3] ^ SYNC_ACTIVE_LOW;
    hs2    = s2_q[1] ^ SYNC_ACTIVE_LOW;
    vs2    = s2_q[0] ^ SYNC_ACTIVE_LOW;
    hs_end = hs2 & ~hs1;
    vs_end = vs2 & ~vs1;
    vs_beg = ~vs2 & vs1;
    lit    = |{s1_q[6:4], s1_q[2:0]};
  end

  // h_d/v_d are the indices of the sample currently in s1.
  always_comb begin
    h_d = (h_q == HMAX) ? HMAX : h_q + 10'd1;
    if (hs_end) h_d = '0;
    v_d = v_q;
    if (hs_end && v_q != HMAX) v_d = v_q + 10'd1;
    if (vs_end) v_d = '0;
    x   = h_d - HST;
    y   = v_d - VST;
    hit = lit && (x < HACT) && (y < VACT);
  end

  always_comb begin
    state_d = state_q;
    minx_d  = minx_q;
    maxx_d  = maxx_q;
    miny_d  = miny_q;
    maxy_d  = maxy_q;
    seen_d  = seen_q;
    bx0_d   = bx0_q;
    bx1_d   = bx1_q;
    by0_d   = by0_q;
    by1_d   = by1_q;
    fnd_d   = fnd_q;
    fv_d    = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      UNLOCKED: begin
        minx_d = '0;
        maxx_d = '0;
        miny_d = '0;
        maxy_d = '0;
        seen_d = 1'b0;
        if (vs_end) state_d = TRACK;
      end
      TRACK: begin
        if (h_d == HMAX) begin
          // hsync lost: drop the partial frame
          state_d = UNLOCKED;
          minx_d  = '0;
          maxx_d  = '0;
          miny_d  = '0;
          maxy_d  = '0;
          seen_d  = 1'b0;
        end else if (vs_beg) begin
          bx0_d  = seen_q ? minx_q : '0;
          bx1_d  = seen_q ? maxx_q : '0;
          by0_d  = seen_q ? miny_q : '0;
          by1_d  = seen_q ? maxy_q : '0;
          fnd_d  = seen_q;
          fv_d   = 1'b1;
          cnt_d  = cnt_q + 8'd1;
          minx_d = '0;
          maxx_d = '0;
          miny_d = '0;
          maxy_d = '0;
          seen_d = 1'b0;
        end else if (hit) begin
          seen_d = 1'b1;
          if (!seen_q || x < minx_q) minx_d = x;
          if (!seen_q || x > maxx_q) maxx_d = x;
          if (!seen_q || y < miny_q) miny_d = y;
          if (!seen_q || y > maxy_q) maxy_d = y;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
      s1_q    <= S1_RST;
      s2_q    <= {IDLE, IDLE};
      h_q     <= '0;
      v_q     <= '0;
      minx_q  <= '0;
      maxx_q  <= '0;
      miny_q  <= '0;
      maxy_q  <= '0;
      seen_q  <= 1'b0;
      bx0_q   <= '0;
      bx1_q   <= '0;
      by0_q   <= '0;
      by1_q   <= '0;
      fnd_q   <= 1'b0;
      fv_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= vga_in;
      s2_q    <= {s1_q[7], s1_q[3]};
      h_q     <= h_d;
      v_q     <= v_d;
      minx_q  <= minx_d;
      maxx_q  <= maxx_d;
      miny_q  <= miny_d;
      maxy_q  <= maxy_d;
      seen_q  <= seen_d;
      bx0_q   <= bx0_d;
      bx1_q   <= bx1_d;
      by0_q   <= by0_d;
      by1_q   <= by1_d;
      fnd_q   <= fnd_d;
      fv_q    <= fv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign box_x0      = bx0_q;
  assign box_x1      = bx1_q;
  assign box_y0      = by0_q;
  assign box_y1      = by1_q;
  assign box_found   = fnd_q;
  assign frame_valid = fv_q;
  assign locked      = (state_q == TRACK);
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_vga_box_tracker.sv
// Bench for vga_box_tracker on a scaled raster:
// line 26 (bp 4, act 16, fp 2, sync 4), frame 15 lines (bp 3, act 8, fp 2, sync 2).
module tb_vga_box_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] vga_in = 8'h88;
  logic [9:0] box_x0, box_x1, box_y0, box_y1;
  logic       box_found, frame_valid, locked;
  logic [7:0] frame_cnt;

  always #5 clk = ~clk;

  vga_box_tracker #(
    .H_START(4),
    .H_ACTIVE(16),
    .V_START(3),
    .V_ACTIVE(8),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vga_in(vga_in),
    .box_x0(box_x0),
    .box_x1(box_x1),
    .box_y0(box_y0),
    .box_y1(box_y1),
    .box_found(box_found),
    .frame_valid(frame_valid),
    .locked(locked),
    .frame_cnt(frame_cnt)
  );

  typedef struct {
    int         bx0, bx1, by0, by1;
    bit         box, corner, porch, hmiss, rstm;
    logic [7:0] col;
    int         np, x0, x1, y0, y1, fnd, cnt;
    int         lk0, lk1, lke;
  } row_t;

  int checks = 0;
  int failures = 0;
  int np, pidx, lk0, lk1;
  row_t rows [9];

  task automatic chk(input string n, input int a, input int e);
    checks = checks + 1;
    if (a != e) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d exp=%0d", n, a, e);
    end
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_x0"}, box_x0, 0);
    chk({n, "_x1"}, box_x1, 0);
    chk({n, "_y0"}, box_y0, 0);
    chk({n, "_y1"}, box_y1, 0);
    chk({n, "_found"}, box_found, 0);
    chk({n, "_fv"}, frame_valid, 0);
    chk({n, "_locked"}, locked, 0);
    chk({n, "_cnt"}, frame_cnt, 0);
  endtask

  function automatic logic [7:0] smp(input int hc, input int vc, input row_t r);
    bit hs_a, vs_a, act, lt;
    int x, y;
    logic [7:0] c;
    hs_a = (hc >= 22);
    vs_a = (vc >= 13);
    act  = (hc >= 4) && (hc < 20) && (vc >= 3) && (vc < 11);
    x    = hc - 4;
    y    = vc - 3;
    lt   = 1'b0;
    if (act) begin
      if (r.box && x >= r.bx0 && x <= r.bx1 && y >= r.by0 && y <= r.by1)
        lt = 1'b1;
      if (r.corner && ((x == 0 && y == 0) || (x == 15 && y == 7)))
        lt = 1'b1;
    end else if (r.porch) begin
      lt = 1'b1;
    end
    c = lt ? (r.col & 8'h77) : 8'h00;
    return {~hs_a, c[6:4], ~vs_a, c[2:0]};
  endfunction

  task automatic drive(input logic [7:0] v, input int idx);
    vga_in = v;
    @(posedge clk);
    #1;
    if (frame_valid) begin
      np   = np + 1;
      pidx = idx;
    end
    if (idx == 0) lk0 = locked;
    if (idx == 1) lk1 = locked;
  endtask

  task automatic run_frame(input int k, input row_t r);
    string p;
    p    = $sformatf("f%0d", k);
    np   = 0;
    pidx = -1;
    lk0  = -1;
    lk1  = -1;
    for (int vc = 0; vc < 15; vc++) begin
      for (int hc = 0; hc < 26; hc++) begin
        if (r.hmiss && vc == 5 && hc == 10)
          for (int j = 0; j < 1100; j++) drive(8'h88, -1);
        if (r.rstm && vc == 5 && hc == 10) begin
          rst_n = 1'b0;
          #1;
          chk_zero({p, "_rst"});
        end
        if (r.rstm && vc == 5 && hc == 13) rst_n = 1'b1;
        drive(smp(hc, vc, r), vc * 26 + hc);
      end
    end
    chk({p, "_pulses"}, np, r.np);
    if (r.np == 1) chk({p, "_pulse_idx"}, pidx, 339);
    chk({p, "_x0"}, box_x0, r.x0);
    chk({p, "_x1"}, box_x1, r.x1);
    chk({p, "_y0"}, box_y0, r.y0);
    chk({p, "_y1"}, box_y1, r.y1);
    chk({p, "_found"}, box_found, r.fnd);
    chk({p, "_cnt"}, frame_cnt, r.cnt);
    chk({p, "_lock0"}, lk0, r.lk0);
    chk({p, "_lock1"}, lk1, r.lk1);
    chk({p, "_lock_end"}, locked, r.lke);
  endtask

  initial begin
    // bx0 bx1 by0 by1 | box cor por hm rst | col | np x0 x1 y0 y1 fnd cnt | lk0 lk1 lke
    rows[0] = '{3, 6, 2, 5, 1, 0, 0, 0, 0, 8'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    rows[1] = '{3, 6, 2, 5, 1, 0, 0, 0, 0, 8'h77, 1, 3, 6, 2, 5, 1, 1, 0, 1, 1};
    rows[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h77, 1, 0, 0, 0, 0, 0, 2, 1, 1, 1};
    rows[3] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h10, 1, 0, 15, 0, 7, 1, 3, 1, 1, 1};
    rows[4] = '{10, 12, 7, 7, 1, 0, 0, 0, 0, 8'h02, 1, 10, 12, 7, 7, 1, 4, 1, 1, 1};
    rows[5] = '{3, 6, 2, 5, 1, 0, 0, 1, 0, 8'h77, 0, 10, 12, 7, 7, 1, 4, 1, 1, 0};
    rows[6] = '{1, 14, 0, 6, 1, 0, 0, 0, 0, 8'h40, 1, 1, 14, 0, 6, 1, 5, 0, 1, 1};
    rows[7] = '{3, 6, 2, 5, 1, 0, 0, 0, 1, 8'h77, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    rows[8] = '{5, 5, 3, 3, 1, 0, 1, 0, 0, 8'h01, 1, 5, 5, 3, 3, 1, 1, 0, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    chk_zero("in_reset");
    rst_n = 1'b1;
    np    = 0;
    for (int i = 0; i < 2000; i++) drive(8'h88, -1);
    chk("idle_pulses", np, 0);
    chk_zero("idle");

    for (int k = 0; k < 9; k++) run_frame(k, rows[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
